// File: rtl/sram_input_pingpong_pkg.sv
// Shared types and SRAM macro geometry for the input ping-pong buffer.
package sram_input_pingpong_pkg;

    localparam int unsigned SRAM_MACRO_WIDTH = 32;
    localparam int unsigned SRAM_MACRO_DEPTH = 1024;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    function automatic int unsigned macro_cols(input int unsigned data_width,
                                               input int unsigned macro_width);
        return data_width / macro_width;
    endfunction

    function automatic int unsigned macro_rows(input int unsigned bank_depth,
                                               input int unsigned macro_depth);
        return bank_depth / macro_depth;
    endfunction

endpackage

// File: rtl/sram_input_pingpong_if.sv
// Producer write stream and consumer random-read port of the ping-pong buffer.
interface sram_input_pingpong_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 11
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  rd_bank_ready;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_done;

    modport master (
        output wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_done,
        input  wr_ready, rd_bank_ready, rd_count, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, rd_en, rd_addr, rd_done,
        output wr_ready, rd_bank_ready, rd_count, rd_valid, rd_data
    );
endinterface

// File: rtl/sram_bank_1w1r.sv
// One SRAM bank: one write port, one registered read port, tiled as rows x columns of macros.
module sram_bank_1w1r
    import sram_input_pingpong_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned BANK_DEPTH  = 2048,
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned MACRO_WIDTH = SRAM_MACRO_WIDTH,
    parameter int unsigned MACRO_DEPTH = SRAM_MACRO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int unsigned ROWS  = macro_rows(BANK_DEPTH, MACRO_DEPTH);
    localparam int unsigned COLS  = macro_cols(DATA_WIDTH, MACRO_WIDTH);
    localparam int unsigned OFF_W = $clog2(MACRO_DEPTH);
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [ROW_W-1:0] wr_row, rd_row;
    logic [OFF_W-1:0] wr_off, rd_off;

    assign wr_off = wr_addr[OFF_W-1:0];
    assign rd_off = rd_addr[OFF_W-1:0];

    if (ROWS > 1) begin : g_rows
        assign wr_row = wr_addr[ADDR_WIDTH-1:OFF_W];
        assign rd_row = rd_addr[ADDR_WIDTH-1:OFF_W];
    end else begin : g_one_row
        assign wr_row = '0;
        assign rd_row = '0;
    end

    // Each column is a stack of ROWS macros sharing the row/offset decode.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [MACRO_WIDTH-1:0] mem [ROWS][MACRO_DEPTH];
        logic [MACRO_WIDTH-1:0] col_q;

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_row][wr_off] <= wr_data[c*MACRO_WIDTH +: MACRO_WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                col_q <= '0;
            end else if (rd_en) begin
                col_q <= mem[rd_row][rd_off];
            end
        end

        assign rd_data[c*MACRO_WIDTH +: MACRO_WIDTH] = col_q;
    end

endmodule

// File: rtl/sram_input_pingpong.sv
// Two-bank ping-pong input buffer: producer fills one bank while the consumer reads the other.
module sram_input_pingpong
    import sram_input_pingpong_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 128,
    parameter int unsigned BANK_DEPTH   = 2048,
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned MACRO_WIDTH  = SRAM_MACRO_WIDTH,
    parameter int unsigned MACRO_DEPTH  = SRAM_MACRO_DEPTH,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_input_pingpong_if.slave bus
);
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BANK_DEPTH - 1);

    localparam logic [1:0] ST_EMPTY   = BANK_EMPTY;
    localparam logic [1:0] ST_FILLING = BANK_FILLING;
    localparam logic [1:0] ST_FULL    = BANK_FULL;

    logic [1:0][1:0]       state_q, state_d;
    logic [1:0][CW-1:0]    count_q, count_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;

    logic                  wr_ready_c, wr_fire_c, close_c;
    logic                  rd_ready_c, rd_fire_c, release_c;
    logic [CW-1:0]         rd_count_c;

    // Handshake decode; the writer never owns a FULL bank, the reader only reads a FULL one.
    always_comb begin
        wr_ready_c = !rst && (state_q[wr_bank_q] != ST_FULL);
        wr_fire_c  = bus.wr_valid && wr_ready_c;
        close_c    = wr_fire_c && (bus.wr_last || (wptr_q == LAST_ADDR));
        rd_ready_c = (state_q[rd_bank_q] == ST_FULL);
        rd_count_c = rd_ready_c ? count_q[rd_bank_q] : '0;
        rd_fire_c  = bus.rd_en && rd_ready_c && (CW'(bus.rd_addr) < rd_count_c);
        release_c  = bus.rd_done && rd_ready_c;
    end

    // Close and release always target different banks, so both may apply in one cycle.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wptr_d    = wptr_q;
        if (wr_fire_c) begin
            if (close_c) begin
                state_d[wr_bank_q] = ST_FULL;
                count_d[wr_bank_q] = CW'(wptr_q) + CW'(1);
                wr_bank_d          = !wr_bank_q;
                wptr_d             = '0;
            end else begin
                state_d[wr_bank_q] = ST_FILLING;
                wptr_d             = wptr_q + ADDR_WIDTH'(1);
            end
        end
        if (release_c) begin
            state_d[rd_bank_q] = ST_EMPTY;
            count_d[rd_bank_q] = '0;
            rd_bank_d          = !rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= {ST_EMPTY, ST_EMPTY};
            count_q   <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wptr_q    <= wptr_d;
        end
    end

    logic [DATA_WIDTH-1:0] bank_q [2];
    logic [DATA_WIDTH-1:0] head_c;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sram_bank_1w1r #(
            .DATA_WIDTH  (DATA_WIDTH),
            .BANK_DEPTH  (BANK_DEPTH),
            .ADDR_WIDTH  (ADDR_WIDTH),
            .MACRO_WIDTH (MACRO_WIDTH),
            .MACRO_DEPTH (MACRO_DEPTH)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_fire_c && (wr_bank_q == 1'(b))),
            .wr_addr (wptr_q),
            .wr_data (bus.wr_data),
            .rd_en   (rd_fire_c && (rd_bank_q == 1'(b))),
            .rd_addr (bus.rd_addr),
            .rd_data (bank_q[b])
        );
    end

    // The bank read register is stage 1; the source bank is remembered for the output mux.
    logic [READ_LATENCY-1:0] vld_q;
    logic                    sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            sel_q <= 1'b0;
        end else begin
            vld_q <= READ_LATENCY'({vld_q, rd_fire_c});
            if (rd_fire_c) begin
                sel_q <= rd_bank_q;
            end
        end
    end

    assign head_c = bank_q[sel_q];

    if (READ_LATENCY == 1) begin : g_direct
        assign bus.rd_data = head_c;
    end else begin : g_delay
        logic [READ_LATENCY-2:0][DATA_WIDTH-1:0] dly_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dly_q <= '0;
            end else begin
                if (vld_q[0]) begin
                    dly_q[0] <= head_c;
                end
                for (int k = 1; k < int'(READ_LATENCY) - 1; k++) begin
                    if (vld_q[k]) begin
                        dly_q[k] <= dly_q[k-1];
                    end
                end
            end
        end

        assign bus.rd_data = dly_q[READ_LATENCY-2];
    end

    assign bus.wr_ready      = wr_ready_c;
    assign bus.rd_bank_ready = rd_ready_c;
    assign bus.rd_count      = rd_count_c;
    assign bus.rd_valid      = vld_q[READ_LATENCY-1];

endmodule
